// File: rtl/gs_issue_if.sv
// Host-side request/response handshake bundle for the gs_issue sequencer.
interface gs_issue_if #(parameter int SIZE = 30);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [SIZE-1:0] req_a;
    logic [SIZE-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [SIZE-1:0] rsp_result;
    logic            rsp_rsign;
    logic            rsp_err;
    logic [1:0]      rsp_op;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_rsign, rsp_err, rsp_op
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_rsign, rsp_err, rsp_op
    );
endinterface

// File: rtl/gs_issue.sv
// Issue/sequencing wrapper around an iterative fixed-point div/sqrt engine:
// latches one request, holds the engine operands for a fixed cycle count, then holds the response.
module gs_issue #(
    parameter int LEADS       = 2,
    parameter int WIDTH       = 28,
    parameter int DIV_CYCLES  = 12,
    parameter int SQRT_CYCLES = 16,
    localparam int SIZE       = LEADS + WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    gs_issue_if.slave       bus,
    output logic            eng_reset,
    output logic [1:0]      eng_op,
    output logic [SIZE-1:0] eng_n0,
    output logic [SIZE-1:0] eng_d0,
    input  logic [SIZE-1:0] eng_result,
    input  logic            eng_rsign
);
    localparam int MAXC = (DIV_CYCLES > SQRT_CYCLES) ? DIV_CYCLES : SQRT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic [1:0]      op;
    logic [SIZE-1:0] a, b;
    logic [SIZE-1:0] res;
    logic            rsign, err;
    logic            ready, accept, last;

    assign last   = (cnt <= CW'(1));
    assign accept = bus.req_valid & ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        ready   = 1'b0;
        case (state)
            IDLE: ready = 1'b1;
            RUN:  if (last) state_n = DONE;
            DONE: begin
                ready = bus.rsp_ready;
                if (bus.rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // reserved ops skip RUN and answer straight from DONE
        if (accept) state_n = bus.req_op[1] ? DONE : RUN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            op    <= '0;
            a     <= '0;
            b     <= '0;
            res   <= '0;
            rsign <= 1'b0;
            err   <= 1'b0;
        end else if (accept) begin
            op  <= bus.req_op;
            a   <= bus.req_a;
            b   <= (bus.req_op == 2'b00) ? bus.req_b : '0;
            case (bus.req_op)
                2'b00:   cnt <= CW'(DIV_CYCLES);
                2'b01:   cnt <= CW'(SQRT_CYCLES);
                default: cnt <= '0;
            endcase
            if (bus.req_op[1]) begin
                res   <= '0;
                rsign <= 1'b0;
                err   <= 1'b1;
            end
        end else if (state == RUN) begin
            if (cnt != '0) cnt <= cnt - CW'(1);
            if (last) begin
                res   <= eng_result;
                rsign <= eng_rsign;
                err   <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.rsp_valid  = (state == DONE);
    assign bus.rsp_result = res;
    assign bus.rsp_rsign  = rsign;
    assign bus.rsp_err    = err;
    assign bus.rsp_op     = op;

    assign eng_reset = (state != RUN);
    assign eng_op    = op;
    assign eng_n0    = a;
    assign eng_d0    = b;
endmodule

// File: tb/tb_gs_issue.sv
// Scoreboard bench for gs_issue with a behavioural engine that only presents
// the true answer on its final cycle, so capture timing and operands are both exercised.
module tb_gs_issue;
    localparam int LEADS = 2, WIDTH = 28, DIVC = 12, SQRTC = 16;
    localparam int SIZE  = LEADS + WIDTH;

    typedef struct {
        logic [1:0]      op;
        logic [SIZE-1:0] res;
        logic            rs;
        logic            err;
        int              due;
        int              runlen;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            eng_reset;
    logic [1:0]      eng_op;
    logic [SIZE-1:0] eng_n0, eng_d0, eng_result;
    logic            eng_rsign;
    logic [SIZE:0]   t;
    int              step = 0, ncyc, cyc = 0;
    int              total = 0, bad = 0, mode = 0;
    int              run_len = 0;
    bit              holding = 0;
    logic [SIZE+3:0] held;
    exp_t            sb[$];

    gs_issue_if #(.SIZE(SIZE)) bus ();

    gs_issue #(.LEADS(LEADS), .WIDTH(WIDTH), .DIV_CYCLES(DIVC), .SQRT_CYCLES(SQRTC)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .eng_reset(eng_reset), .eng_op(eng_op), .eng_n0(eng_n0), .eng_d0(eng_d0),
        .eng_result(eng_result), .eng_rsign(eng_rsign)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // {rsign, value}: value = floor((n<<WIDTH)/d) or floor(sqrt(n<<WIDTH))
    function automatic logic [SIZE:0] calc(input logic [1:0] o, input logic [SIZE-1:0] n, input logic [SIZE-1:0] d);
        longint unsigned x, q, r, bv;
        x = 64'(n) << WIDTH;
        q = 0;
        if (o == 2'b00) begin
            if (d == '0) return '0;
            q = x / 64'(d);
            r = x % 64'(d);
        end else begin
            bv = 64'h1 << 62;
            while (bv > x) bv = bv >> 2;
            while (bv != 0) begin
                if (x >= q + bv) begin
                    x = x - (q + bv);
                    q = (q >> 1) + bv;
                end else q = q >> 1;
                bv = bv >> 2;
            end
            r = x;
        end
        return {r != 0, q[SIZE-1:0]};
    endfunction

    // behavioural engine: counts from its restart, right answer only on its last cycle
    always @(posedge clk) step <= eng_reset ? 0 : step + 1;
    always_comb begin
        ncyc = (eng_op == 2'b00) ? DIVC : SQRTC;
        t = calc(eng_op, eng_n0, eng_d0);
        if (eng_op != 2'b00) t[SIZE-1:0] = t[SIZE-1:0] ^ eng_d0;
        if (step == ncyc - 1) {eng_rsign, eng_result} = t;
        else {eng_rsign, eng_result} = {~t[SIZE], t[SIZE-1:0] ^ SIZE'(step + 1)};
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic send(input logic [1:0] o, input logic [SIZE-1:0] a_in, input logic [SIZE-1:0] b_in);
        exp_t e;
        logic [SIZE:0] r;
        int n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op = o;
        bus.req_a = a_in;
        bus.req_b = b_in;
        while (!bus.req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            chk("accept_timeout", 64'(n), 64'(0));
            return;
        end
        e.op = o;
        if (o[1]) begin
            e.res = '0; e.rs = 1'b0; e.err = 1'b1; e.runlen = 0;
        end else begin
            r = calc(o, a_in, (o == 2'b00) ? b_in : '0);
            e.res = r[SIZE-1:0]; e.rs = r[SIZE]; e.err = 1'b0;
            e.runlen = (o == 2'b00) ? DIVC : SQRTC;
        end
        e.due = cyc + e.runlen + 1;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_op = 2'($urandom);
        bus.req_a = SIZE'($urandom);
        bus.req_b = SIZE'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || holding) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    always @(posedge clk) begin
        #1;
        case (mode)
            0: bus.rsp_ready = 1'b1;
            1: bus.rsp_ready = ($urandom_range(0, 3) != 0);
            default: bus.rsp_ready = 1'b0;
        endcase
    end

    // response monitor: compares each new response and its latency, then stability while stalled
    always @(negedge clk) begin
        if (!reset) begin
            holding = 0;
            run_len = 0;
        end else begin
            if (!eng_reset) run_len++;
            else if (run_len != 0) begin
                chk("run_len", 64'(run_len), 64'((sb.size() != 0) ? sb[0].runlen : -1));
                run_len = 0;
            end
            if (bus.rsp_valid) begin
                chk("req_ready_in_done", 64'(bus.req_ready), 64'(bus.rsp_ready));
                chk("eng_reset_in_done", 64'(eng_reset), 64'(1));
                if (!holding) begin
                    if (sb.size() == 0) chk("spurious_rsp", 64'(1), 64'(0));
                    else begin
                        chk("rsp_result", 64'(bus.rsp_result), 64'(sb[0].res));
                        chk("rsp_rsign", 64'(bus.rsp_rsign), 64'(sb[0].rs));
                        chk("rsp_err", 64'(bus.rsp_err), 64'(sb[0].err));
                        chk("rsp_op", 64'(bus.rsp_op), 64'(sb[0].op));
                        chk("latency", 64'(cyc), 64'(sb[0].due));
                    end
                    held = {bus.rsp_op, bus.rsp_err, bus.rsp_rsign, bus.rsp_result};
                    holding = 1;
                end else begin
                    chk("rsp_stable", 64'({bus.rsp_op, bus.rsp_err, bus.rsp_rsign, bus.rsp_result}), 64'(held));
                end
                if (bus.rsp_ready) begin
                    holding = 0;
                    if (sb.size() != 0) void'(sb.pop_front());
                end
            end else holding = 0;
        end
    end

    initial begin
        int n;
        logic [1:0] o;
        bus.req_valid = 1'b0;
        bus.req_op = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_eng_reset", 64'(eng_reset), 64'(1));
        chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
        chk("rst_operands", 64'({eng_n0, eng_d0}), 64'(0));
        chk("rst_result", 64'(bus.rsp_result), 64'(0));
        #2 reset = 1'b1;

        send(2'b00, 30'h0C00_0000, 30'h1000_0000);
        idle();
        wait_drain();

        send(2'b01, 30'h1000_0000, 30'h2AAA_5555);
        idle();
        wait_drain();

        send(2'b11, SIZE'($urandom), SIZE'($urandom));
        idle();
        chk("reserved_eng_reset", 64'(eng_reset), 64'(1));
        wait_drain();

        // hold the response off, then release it together with a new request
        mode = 2;
        send(2'b00, 30'h0123_4567, 30'h0765_4321);
        idle();
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_seen", 64'(bus.rsp_valid), 64'(1));
        repeat (5) @(negedge clk);
        chk("bp_req_ready", 64'(bus.req_ready), 64'(0));
        mode = 0;
        send(2'b01, 30'h3FFF_FFFF, 30'h1);
        @(negedge clk);
        chk("b2b_run_entered", 64'(eng_reset), 64'(0));
        chk("b2b_rsp_dropped", 64'(bus.rsp_valid), 64'(0));
        bus.req_valid = 1'b0;
        wait_drain();

        // reset in the middle of a divide
        send(2'b00, 30'h2000_0000, 30'h0300_0000);
        idle();
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("midrst_eng_reset", 64'(eng_reset), 64'(1));
        chk("midrst_req_ready", 64'(bus.req_ready), 64'(1));
        sb.delete();
        holding = 0;
        run_len = 0;
        @(negedge clk);
        #2 reset = 1'b1;
        send(2'b00, 30'h0C00_0000, 30'h1000_0000);
        idle();
        wait_drain();

        mode = 1;
        for (int i = 0; i < 60; i++) begin
            n = $urandom_range(0, 9);
            o = (n < 4) ? 2'b00 : (n < 8) ? 2'b01 : (n == 8) ? 2'b10 : 2'b11;
            send(o, SIZE'($urandom), SIZE'($urandom_range(1, 32'h3FFF_FFFF)));
            if ($urandom_range(0, 2) == 0) begin
                idle();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        idle();
        wait_drain();
        mode = 0;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
